// File: rtl/cbb_pkg.sv
// Shared helpers for the cbb_* blocks: index-width math and arbiter state encoding.
package cbb_pkg;

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Index width never collapses to zero, so a single-bit index survives degenerate sizes.
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/cbb_rr_pick.sv
// Combinational round-robin picker: first set vld at or after ptr, wrapping to index 0.
module cbb_rr_pick
  import cbb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     vld_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  logic [2*N-1:0] dbl;
  logic           found;

  // Low half keeps only requesters at/after ptr; the unmasked upper half supplies the wrap.
  always_comb begin
    dbl = '0;
    for (int j = 0; j < N; j++) begin
      dbl[j]     = vld_i[j] && (IDX_W'(j) >= ptr_i);
      dbl[N + j] = vld_i[j];
    end
    found     = 1'b0;
    gnt_idx_o = '0;
    for (int k = 0; k < 2 * N; k++) begin
      if (!found && dbl[k]) begin
        found     = 1'b1;
        gnt_idx_o = (k >= N) ? IDX_W'(k - N) : IDX_W'(k);
      end
    end
    gnt_oh_o = '0;
    if (found) gnt_oh_o[gnt_idx_o] = 1'b1;
  end

  assign any_o = |vld_i;

endmodule

// File: rtl/cbb_reg_wr_arb.sv
// Round-robin write arbiter owning a shared config register, with per-requester lock.
module cbb_reg_wr_arb
  import cbb_pkg::*;
#(
  parameter int               NUM_REQ  = 4,
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int              IDX_W    = idx_w(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     arb_en_i,
  input  logic [NUM_REQ-1:0]       req_vld_i,
  input  logic [NUM_REQ-1:0]       req_lock_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_rdy_o,
  output logic [WIDTH-1:0]         reg_q_o,
  output logic                     upd_vld_o,
  output logic [IDX_W-1:0]         upd_src_o
);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             upd_vld_q, upd_vld_d;
  logic [IDX_W-1:0] upd_src_q, upd_src_d;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [NUM_REQ-1:0] rdy;
  logic [IDX_W-1:0]   acc_idx;
  logic               acc;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  cbb_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .vld_i     (req_vld_i),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  always_comb begin
    rdy = '0;
    if (!rst_i && arb_en_i) begin
      if (state_q == ST_ARB) begin
        if (gnt_any) rdy = gnt_oh;
      end else begin
        rdy[owner_q] = req_vld_i[owner_q];
      end
    end
  end

  assign acc_idx = (state_q == ST_ARB) ? gnt_idx : owner_q;
  assign acc     = |(req_vld_i & rdy);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    reg_d     = reg_q;
    upd_vld_d = 1'b0;
    upd_src_d = upd_src_q;
    if (acc) begin
      reg_d     = req_data_i[int'(acc_idx) * WIDTH +: WIDTH];
      upd_vld_d = 1'b1;
      upd_src_d = acc_idx;
      if (req_lock_i[acc_idx]) begin
        state_d = ST_LOCK;
        owner_d = acc_idx;
      end else begin
        state_d = ST_ARB;
        ptr_d   = wrap_inc(acc_idx);
      end
    end else if (arb_en_i && state_q == ST_LOCK) begin
      // Owner went idle while holding the lock: release it and move past the owner.
      state_d = ST_ARB;
      ptr_d   = wrap_inc(owner_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_ARB;
      ptr_q     <= '0;
      owner_q   <= '0;
      reg_q     <= INIT_VAL;
      upd_vld_q <= 1'b0;
      upd_src_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      reg_q     <= reg_d;
      upd_vld_q <= upd_vld_d;
      upd_src_q <= upd_src_d;
    end
  end

  assign req_rdy_o = rdy;
  assign reg_q_o   = reg_q;
  assign upd_vld_o = upd_vld_q;
  assign upd_src_o = upd_src_q;

endmodule

// File: tb/tb_cbb_reg_wr_arb.sv
// Bench for cbb_reg_wr_arb: a 4-requester and a 3-requester instance against a queue-free reference model.
module tb_cbb_reg_wr_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, arb_en;
  logic [3:0]  vld4, lock4, rdy4;
  logic [31:0] d4;
  logic [2:0]  vld3, lock3, rdy3;
  logic [23:0] d3;
  logic [7:0]  reg4, reg3;
  logic        upd4, upd3;
  logic [1:0]  src4, src3;

  int n_vec = 0;
  int n_err = 0;

  cbb_reg_wr_arb #(.NUM_REQ(4), .WIDTH(8), .INIT_VAL(8'h00)) u4 (
    .clk_i(clk), .rst_i(rst), .arb_en_i(arb_en),
    .req_vld_i(vld4), .req_lock_i(lock4), .req_data_i(d4),
    .req_rdy_o(rdy4), .reg_q_o(reg4), .upd_vld_o(upd4), .upd_src_o(src4)
  );

  cbb_reg_wr_arb #(.NUM_REQ(3), .WIDTH(8), .INIT_VAL(8'hC3)) u3 (
    .clk_i(clk), .rst_i(rst), .arb_en_i(arb_en),
    .req_vld_i(vld3), .req_lock_i(lock3), .req_data_i(d3),
    .req_rdy_o(rdy3), .reg_q_o(reg3), .upd_vld_o(upd3), .upd_src_o(src3)
  );

  // Reference model: index 0 tracks u4, index 1 tracks u3.
  int mn[2]    = '{4, 3};
  int minit[2] = '{8'h00, 8'hC3};
  int mptr[2]  = '{0, 0};
  int mown[2]  = '{0, 0};
  int mreg[2]  = '{8'h00, 8'hC3};
  int mupd[2]  = '{0, 0};
  int msrc[2]  = '{0, 0};
  bit mlck[2]  = '{1'b0, 1'b0};

  function automatic logic [3:0] exp_rdy(input int m, input logic r, input logic e, input logic [3:0] v);
    logic [3:0] g;
    g = '0;
    if (r || !e) return g;
    if (mlck[m]) begin
      g[mown[m]] = v[mown[m]];
      return g;
    end
    for (int k = 0; k < mn[m]; k++) begin
      int i;
      i = (mptr[m] + k) % mn[m];
      if (v[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_edge(input int m, input logic r, input logic e,
                            input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
    logic [3:0] g;
    int w;
    g = exp_rdy(m, r, e, v);
    mupd[m] = 0;
    if (r) begin
      mreg[m] = minit[m]; mptr[m] = 0; mlck[m] = 1'b0; mown[m] = 0; msrc[m] = 0;
      return;
    end
    if (!e) return;
    w = -1;
    for (int i = 0; i < 4; i++) if (g[i]) w = i;
    if (w >= 0) begin
      mreg[m] = int'(d[w*8 +: 8]);
      mupd[m] = 1;
      msrc[m] = w;
      if (l[w]) begin
        mlck[m] = 1'b1; mown[m] = w;
      end else begin
        mlck[m] = 1'b0; mptr[m] = (w + 1) % mn[m];
      end
    end else if (mlck[m]) begin
      mlck[m] = 1'b0;
      mptr[m] = (mown[m] + 1) % mn[m];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive, check ready at negedge, clock, check outputs at posedge+1.
  task automatic step(input logic r, input logic e,
                      input logic [3:0] v4, input logic [3:0] l4, input logic [31:0] dd4,
                      input logic [2:0] v3, input logic [2:0] l3, input logic [23:0] dd3);
    logic [3:0] e4, e3;
    rst = r; arb_en = e;
    vld4 = v4; lock4 = l4; d4 = dd4;
    vld3 = v3; lock3 = l3; d3 = dd3;
    #4;
    e4 = exp_rdy(0, r, e, v4);
    e3 = exp_rdy(1, r, e, {1'b0, v3});
    chk("rdy4", 32'(rdy4), 32'(e4));
    chk("rdy3", 32'(rdy3), 32'(e3));
    @(posedge clk);
    model_edge(0, r, e, v4, l4, dd4);
    model_edge(1, r, e, {1'b0, v3}, {1'b0, l3}, {8'h00, dd3});
    #1;
    chk("reg4", 32'(reg4), mreg[0]);
    chk("upd4", 32'(upd4), mupd[0]);
    chk("src4", 32'(src4), msrc[0]);
    chk("reg3", 32'(reg3), mreg[1]);
    chk("upd3", 32'(upd3), mupd[1]);
    chk("src3", 32'(src3), msrc[1]);
  endtask

  task automatic s4(input logic r, input logic e, input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
    step(r, e, v, l, d, 3'b000, 3'b000, 24'h0);
  endtask

  task automatic s3(input logic [2:0] v, input logic [2:0] l, input logic [23:0] d);
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 32'h0, v, l, d);
  endtask

  logic [7:0] lk_dat [3] = '{8'hAA, 8'hBB, 8'hCC};
  int         lk_src [5] = '{1, 1, 1, 2, 0};
  int         rr3    [3] = '{2, 0, 2};

  initial begin
    rst = 1'b1; arb_en = 1'b1;
    vld4 = '0; lock4 = '0; d4 = '0;
    vld3 = '0; lock3 = '0; d3 = '0;
    @(posedge clk); #1;

    // Reset held with every requester valid: nothing may be granted.
    step(1'b1, 1'b1, 4'hF, 4'h0, 32'h13121110, 3'b111, 3'b000, 24'h020100);
    step(1'b1, 1'b1, 4'hF, 4'h0, 32'h13121110, 3'b111, 3'b000, 24'h020100);
    chk("rst_reg4", 32'(reg4), 32'h00);
    chk("rst_upd4", 32'(upd4), 32'h0);
    chk("rst_reg3", 32'(reg3), 32'hC3);

    // Fairness: continuous requests rotate 0,1,2,3,...
    for (int k = 0; k < 8; k++) begin
      s4(1'b0, 1'b1, 4'hF, 4'h0, 32'h13121110);
      chk("fair_reg", 32'(reg4), 32'(8'h10 + k % 4));
      chk("fair_src", 32'(src4), 32'(k % 4));
    end

    // Lock: move ptr to 1, then req1 holds the register for three beats.
    s4(1'b0, 1'b1, 4'b0001, 4'b0000, 32'h00000009);
    for (int k = 0; k < 5; k++) begin
      s4(1'b0, 1'b1, 4'b0111, (k < 2) ? 4'b0010 : 4'b0000,
         {8'h33, 8'h22, (k < 3) ? lk_dat[k] : 8'h11, 8'h00});
      chk("lock_src", 32'(src4), 32'(lk_src[k]));
    end

    // Abandon: req3 locks, then goes idle for a cycle; ptr wraps to 0.
    s4(1'b0, 1'b1, 4'b1000, 4'b1000, 32'h55000000);
    chk("abn_reg", 32'(reg4), 32'h55);
    s4(1'b0, 1'b1, 4'b0001, 4'b0000, 32'h000000EE);
    chk("abn_nowr", 32'(upd4), 32'h0);
    s4(1'b0, 1'b1, 4'b1001, 4'b0000, 32'h66000077);
    chk("abn_next", 32'(src4), 32'h0);

    // Freeze in LOCK, then reset mid-LOCK with a beat on the reset edge.
    s4(1'b0, 1'b1, 4'b0100, 4'b0100, 32'h00990000);
    for (int k = 0; k < 3; k++) begin
      s4(1'b0, 1'b0, 4'hF, 4'hF, 32'h44444444);
      chk("frz_reg", 32'(reg4), 32'h99);
      chk("frz_upd", 32'(upd4), 32'h0);
    end
    s4(1'b1, 1'b1, 4'b0100, 4'b0100, 32'h00770000);
    chk("rlk_reg", 32'(reg4), 32'h00);
    s4(1'b0, 1'b1, 4'hF, 4'h0, 32'h13121110);
    chk("rlk_src", 32'(src4), 32'h0);

    // Three-requester wrap: grant 2 must return the pointer to 0.
    s3(3'b001, 3'b000, 24'h0302F1);
    for (int k = 0; k < 3; k++) begin
      s3(3'b101, 3'b000, 24'hA2B1C0);
      chk("wrap3_src", 32'(src3), 32'(rr3[k]));
    end

    // Random traffic on both instances.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 24'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
